// File: rtl/noc_config_pkg.sv
// noc_config_pkg: shared switch state type and round-robin pick helper
package noc_config_pkg;
  localparam int MAX_INPUTS = 16;
  typedef enum logic {IDLE, BUSY} noc_switch_state_e;
  function automatic logic [3:0] noc_rr_pick(input logic [MAX_INPUTS-1:0] req, input logic [3:0] last, input int n);
    logic found;
    int idx;
    noc_rr_pick = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_INPUTS; k++) begin
      idx = (int'(last) + k) % n;
      if (k <= n && !found && req[idx[3:0]]) begin
        noc_rr_pick = idx[3:0];
        found = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/noc_flit_fifo.sv
// noc_flit_fifo: registered power-of-two FIFO with push/pop/full/empty
module noc_flit_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/noc_output_switch_rr.sv
// noc_output_switch_rr: N-input round-robin wormhole output port with registered output FIFO
module noc_output_switch_rr
  import noc_config_pkg::*;
#(
  parameter int N_INPUTS = 5,
  parameter int FLIT_W = 64,
  parameter int OUT_DEPTH = 2,
  localparam int ID_W = $clog2(N_INPUTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_INPUTS-1:0]          flit_in_valid,
  output logic [N_INPUTS-1:0]          flit_in_ready,
  input  logic [N_INPUTS*FLIT_W-1:0]   flit_in_data,
  input  logic [N_INPUTS-1:0]          flit_in_last,
  output logic                         flit_out_valid,
  input  logic                         flit_out_ready,
  output logic [FLIT_W-1:0]            flit_out_data,
  output logic                         flit_out_last,
  output logic                         busy,
  output logic [ID_W-1:0]              grant_id
);
  noc_switch_state_e state, state_d;
  logic [ID_W-1:0] grant, grant_d, last_grant, last_grant_d;
  logic full, empty, in_fire, sel_last;
  logic [FLIT_W-1:0] sel_data;
  always_comb begin
    sel_data = flit_in_data[grant*FLIT_W +: FLIT_W];
    sel_last = flit_in_last[grant];
    in_fire = state == BUSY && !full && flit_in_valid[grant];
    flit_in_ready = (state == BUSY && !full) ? N_INPUTS'(1) << grant : '0;
    state_d = state;
    grant_d = grant;
    last_grant_d = last_grant;
    if (state == IDLE && |flit_in_valid) begin
      state_d = BUSY;
      grant_d = ID_W'(noc_rr_pick(MAX_INPUTS'(flit_in_valid), 4'(last_grant), N_INPUTS));
    end
    // the grant is held until the tail flit is actually accepted
    if (in_fire && sel_last) begin
      state_d = IDLE;
      last_grant_d = grant;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= ID_W'(N_INPUTS - 1);
    end else begin
      state <= state_d;
      grant <= grant_d;
      last_grant <= last_grant_d;
    end
  end
  assign busy = state == BUSY;
  assign grant_id = grant;
  assign flit_out_valid = !empty;
  noc_flit_fifo #(.WIDTH(FLIT_W + 1), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(in_fire),
    .wdata({sel_last, sel_data}),
    .full(full),
    .pop(flit_out_ready),
    .rdata({flit_out_last, flit_out_data}),
    .empty(empty)
  );
endmodule

// File: tb/tb_noc_output_switch_rr.sv
// tb_noc_output_switch_rr: directed checks on the 5-input switch plus random traffic on an 8-input one
module tb_noc_output_switch_rr;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [4:0] v, l, ir;
  logic [319:0] d;
  logic ov, oready, ol, busy;
  logic [63:0] od;
  logic [2:0] gid;
  logic [7:0] v8, l8, r8;
  logic [255:0] d8;
  logic ov8, or8, ol8, busy8;
  logic [31:0] od8;
  logic [2:0] gid8;
  int total, bad;
  logic [7:0] sq [8];
  logic [7:0] esq [8];
  logic [3:0] ix [8];
  logic [3:0] ln [8];
  logic [3:0] eix [8];
  int wt [8];

  noc_output_switch_rr dut (
    .clk(clk), .rst(rst), .flit_in_valid(v), .flit_in_ready(ir), .flit_in_data(d), .flit_in_last(l),
    .flit_out_valid(ov), .flit_out_ready(oready), .flit_out_data(od), .flit_out_last(ol),
    .busy(busy), .grant_id(gid)
  );
  noc_output_switch_rr #(.N_INPUTS(8), .FLIT_W(32), .OUT_DEPTH(4)) dut8 (
    .clk(clk), .rst(rst), .flit_in_valid(v8), .flit_in_ready(r8), .flit_in_data(d8), .flit_in_last(l8),
    .flit_out_valid(ov8), .flit_out_ready(or8), .flit_out_data(od8), .flit_out_last(ol8),
    .busy(busy8), .grant_id(gid8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; v = '0; l = '0; d = '0; oready = 1'b1;
    v8 = '0; l8 = '0; d8 = '0; or8 = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (ir !== 5'b0) begin bad++; $display("FAIL reset_ready got=%b exp=%b", ir, 5'b0); end
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", ov); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (gid !== 3'd0) begin bad++; $display("FAIL reset_grant got=%0d exp=0", gid); end
    total++; if (ov8 !== 1'b0 || busy8 !== 1'b0) begin bad++; $display("FAIL reset_dut8 got=%b%b exp=00", ov8, busy8); end
  endtask

  task automatic test_single();
    v[0] = 1'b1; l[0] = 1'b0; d[63:0] = 64'hA000;
    total++; if (ir !== 5'b0) begin bad++; $display("FAIL idle_ready got=%b exp=00000", ir); end
    step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    total++; if (gid !== 3'd0) begin bad++; $display("FAIL single_grant got=%0d exp=0", gid); end
    total++; if (ir !== 5'b00001) begin bad++; $display("FAIL single_ready got=%b exp=00001", ir); end
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL single_bubble got=%b exp=0", ov); end
    step();
    total++; if (ov !== 1'b1 || od !== 64'hA000 || ol !== 1'b0) begin bad++; $display("FAIL single_f0 got=%b/%h/%b exp=1/a000/0", ov, od, ol); end
    d[63:0] = 64'hA001;
    step();
    total++; if (ov !== 1'b1 || od !== 64'hA001 || ol !== 1'b0) begin bad++; $display("FAIL single_f1 got=%b/%h/%b exp=1/a001/0", ov, od, ol); end
    d[63:0] = 64'hA002; l[0] = 1'b1;
    step();
    total++; if (ov !== 1'b1 || od !== 64'hA002 || ol !== 1'b1) begin bad++; $display("FAIL single_f2 got=%b/%h/%b exp=1/a002/1", ov, od, ol); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_release got=%b exp=0", busy); end
    v[0] = 1'b0; l[0] = 1'b0;
    step();
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", ov); end
  endtask

  task automatic test_round_robin();
    int got[$];
    int exp_ids[6] = '{1, 2, 4, 1, 2, 4};
    v = 5'b10110; l = 5'b10110;
    d[127:64] = 64'hB1; d[191:128] = 64'hB2; d[319:256] = 64'hB4;
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      if (busy && (ir & v) != 5'b0) got.push_back(int'(gid));
      step();
    end
    v = '0; l = '0;
    total++; if (got.size() != 6) begin bad++; $display("FAIL rr_count got=%0d exp=6", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      total++; if (got[k] != exp_ids[k]) begin bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, got[k], exp_ids[k]); end
    end
    step();
    step();
  endtask

  task automatic test_lock();
    v[3] = 1'b1; l[3] = 1'b0; d[255:192] = 64'hC0;
    step();
    total++; if (busy !== 1'b1 || gid !== 3'd3) begin bad++; $display("FAIL lock_grant got=%b/%0d exp=1/3", busy, gid); end
    step();
    v[0] = 1'b1; l[0] = 1'b1; d[63:0] = 64'hD0; d[255:192] = 64'hC1;
    step();
    total++; if (ir[0] !== 1'b0 || gid !== 3'd3) begin bad++; $display("FAIL lock_hold got=%b/%0d exp=0/3", ir[0], gid); end
    v[3] = 1'b0;
    step();
    step();
    total++; if (busy !== 1'b1 || gid !== 3'd3 || ir[0] !== 1'b0) begin bad++; $display("FAIL lock_gap got=%b/%0d/%b exp=1/3/0", busy, gid, ir[0]); end
    v[3] = 1'b1; d[255:192] = 64'hC2;
    step();
    d[255:192] = 64'hC3; l[3] = 1'b1;
    step();
    total++; if (busy !== 1'b0 || ir !== 5'b0) begin bad++; $display("FAIL lock_tail got=%b/%b exp=0/00000", busy, ir); end
    v[3] = 1'b0; l[3] = 1'b0;
    step();
    total++; if (gid !== 3'd0 || ir !== 5'b00001) begin bad++; $display("FAIL lock_next got=%0d/%b exp=0/00001", gid, ir); end
    step();
    v[0] = 1'b0; l[0] = 1'b0;
    step();
  endtask

  task automatic test_stall();
    logic [64:0] got[$];
    logic [63:0] b [4] = '{64'hB000, 64'hB001, 64'hB002, 64'hB003};
    logic inf, outf;
    int k = 0;
    oready = 1'b0; v[1] = 1'b1; l[1] = 1'b0; d[127:64] = b[0];
    step();
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      oready = c >= 5;
      if (c >= 1 && c < 5) begin
        total++; if (ov !== 1'b1 || od !== b[0]) begin bad++; $display("FAIL stall_hold got=%b/%h exp=1/%h", ov, od, b[0]); end
      end
      if (c == 4) begin
        total++; if (k != 2) begin bad++; $display("FAIL stall_accepted got=%0d exp=2", k); end
        total++; if (ir[1] !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", ir[1]); end
      end
      inf = v[1] & ir[1];
      outf = ov & oready;
      if (outf) got.push_back({ol, od});
      step();
      if (inf) begin
        k++;
        if (k == 4) begin
          v[1] = 1'b0; l[1] = 1'b0;
        end else begin
          d[127:64] = b[k]; l[1] = k == 3;
        end
      end
    end
    oready = 1'b1;
    total++; if (got.size() != 4) begin bad++; $display("FAIL stall_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      total++; if (got[i] !== {i == 3, b[i]}) begin bad++; $display("FAIL stall_flit[%0d] got=%h exp=%h", i, got[i], {i == 3, b[i]}); end
    end
  endtask

  task automatic test_reset_mid();
    v[2] = 1'b1; l[2] = 1'b1; d[191:128] = 64'hE0;
    step();
    step();
    v[2] = 1'b0; l[2] = 1'b0;
    v[3] = 1'b1; l[3] = 1'b0; d[255:192] = 64'hF0;
    step();
    step();
    d[255:192] = 64'hF1;
    step();
    rst = 1'b1; v[2] = 1'b1; l[2] = 1'b1;
    step();
    rst = 1'b0;
    total++; if (ir !== 5'b0 || ov !== 1'b0) begin bad++; $display("FAIL rstmid_io got=%b/%b exp=00000/0", ir, ov); end
    total++; if (busy !== 1'b0 || gid !== 3'd0) begin bad++; $display("FAIL rstmid_state got=%b/%0d exp=0/0", busy, gid); end
    step();
    total++; if (busy !== 1'b1 || gid !== 3'd2) begin bad++; $display("FAIL rstmid_regrant got=%b/%0d exp=1/2", busy, gid); end
    v[3] = 1'b0;
    step();
    v[2] = 1'b0; l[2] = 1'b0;
    step();
    step();
  endtask

  task automatic test_random_n8();
    int tails = 0;
    logic in_pkt = 1'b0;
    logic [2:0] cur = '0;
    logic [2:0] src;
    logic [7:0] inf;
    logic outf;
    for (int i = 0; i < 8; i++) begin
      sq[i] = '0; esq[i] = '0; ix[i] = '0; eix[i] = '0; wt[i] = 0;
      ln[i] = 4'($urandom_range(1, 4));
      d8[i*32 +: 32] = {4'(i), sq[i], ix[i], ln[i], 12'h0};
      l8[i] = ln[i] == 4'd1;
    end
    v8 = '1;
    for (int c = 0; c < 6000 && tails < 200; c++) begin
      inf = v8 & r8;
      outf = ov8 & or8;
      if (outf) begin
        src = od8[30:28];
        if (in_pkt) begin
          total++; if (src !== cur) begin bad++; $display("FAIL rnd_interleave got=%0d exp=%0d", src, cur); end
        end
        total++; if (od8[27:16] !== {esq[src], eix[src]}) begin bad++; $display("FAIL rnd_order src=%0d got=%h exp=%h", src, od8[27:16], {esq[src], eix[src]}); end
        total++; if (ol8 !== (eix[src] == od8[15:12] - 4'd1)) begin bad++; $display("FAIL rnd_last src=%0d got=%b exp=%b", src, ol8, eix[src] == od8[15:12] - 4'd1); end
        if (ol8) begin
          eix[src] = '0; esq[src] = esq[src] + 8'd1; in_pkt = 1'b0; tails++;
          for (int j = 0; j < 8; j++) wt[j] = (j == int'(src)) ? 0 : wt[j] + 1;
          for (int j = 0; j < 8; j++) begin
            total++; if (wt[j] > 7) begin bad++; $display("FAIL rnd_fair in=%0d got=%0d exp<=7", j, wt[j]); end
          end
        end else begin
          eix[src] = eix[src] + 4'd1; in_pkt = 1'b1; cur = src;
        end
      end
      step();
      for (int i = 0; i < 8; i++) begin
        if (inf[i]) begin
          ix[i] = ix[i] + 4'd1;
          if (ix[i] == ln[i]) begin
            ix[i] = '0; sq[i] = sq[i] + 8'd1; ln[i] = 4'($urandom_range(1, 4));
          end
          d8[i*32 +: 32] = {4'(i), sq[i], ix[i], ln[i], 12'h0};
          l8[i] = ix[i] == ln[i] - 4'd1;
        end
      end
      or8 = $urandom_range(0, 3) != 0;
    end
    v8 = '0;
    total++; if (tails < 200) begin bad++; $display("FAIL rnd_progress got=%0d exp>=200", tails); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_stall();
    test_reset_mid();
    test_random_n8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
